// File: rtl/inst_fetch_queue_if.sv
// Bus bundle between the fetch queue, instruction memory and the execute stage.
// master: fetch queue side; slave: memory + downstream + control side.
interface inst_fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          mem_req;
  logic [29:0]   mem_addr;
  logic          mem_ack;
  logic [31:0]   mem_rdata;

  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [31:0]   out_pc;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          halt;
  logic [CW-1:0] count;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output out_valid, out_inst, out_pc,
    input  out_ready,
    input  redirect, redirect_pc, halt,
    output count
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  out_valid, out_inst, out_pc,
    output out_ready,
    output redirect, redirect_pc, halt,
    input  count
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: owns the PC, keeps at most one request in
// flight to a variable-latency instruction memory and buffers {pc, inst}
// pairs for the execute stage.
//
// state | meaning
// IDLE  | no request outstanding
// REQ   | request at addr_q outstanding, response will be pushed
// DROP  | request outstanding for a flushed stream, response discarded
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                clock,
  input logic                reset,
  inst_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          req_q, req_d;
  logic [29:0]   addr_q, addr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];

  logic acked;
  logic push;
  logic pop;
  logic issue_ok;

  // Handshake qualifiers; ack only counts while a request is actually out,
  // and redirect suppresses both push and pop.
  always_comb begin
    acked = req_q & bus.mem_ack;
    push  = acked & (state_q == REQ) & ~bus.redirect;
    pop   = (count_q != '0) & bus.out_ready & ~bus.redirect;
  end

  // Occupancy and pointer update; a redirect empties the queue outright.
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (bus.redirect) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_q + CW'(push) - CW'(pop);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      wr_ptr_d = wr_ptr_q + AW'(push);
    end
    // A new request is only allowed when its response is sure to find a slot.
    issue_ok = ~bus.halt & (count_d < CW'(DEPTH));
  end

  // Next state, PC and request/address registers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc & ~32'h3;
    end else if (push) begin
      pc_d = pc_q + 32'd4;
    end

    case (state_q)
      IDLE: begin
        if (issue_ok) state_d = REQ;
      end
      REQ: begin
        if (acked) begin
          state_d = issue_ok ? REQ : IDLE;
        end else if (bus.redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (acked) state_d = issue_ok ? REQ : IDLE;
      end
      default: state_d = IDLE;
    endcase

    req_d  = (state_d != IDLE);
    addr_d = addr_q;
    // Address only moves when a fresh request starts; it is held while waiting.
    if ((state_d == REQ) && ((state_q == IDLE) || acked)) begin
      addr_d = pc_d[31:2];
    end
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC[31:2];
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage; cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        inst_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      inst_mem_q[wr_ptr_q] <= bus.mem_rdata;
      pc_mem_q[wr_ptr_q]   <= pc_q;
    end
  end

  // Outputs straight from registers and the head slot.
  always_comb begin
    bus.mem_req   = req_q;
    bus.mem_addr  = addr_q;
    bus.out_valid = (count_q != '0);
    bus.out_inst  = inst_mem_q[rd_ptr_q];
    bus.out_pc    = pc_mem_q[rd_ptr_q];
    bus.count     = count_q;
  end
endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Instruction fetch front end that sits directly upstream of the arithmetic execute machine (decoder + regfile + ALU).
- Owns the PC and requests instruction words from a variable-latency instruction memory over a req/ack handshake.
- Buffers {pc, inst} pairs in a small FIFO and presents them downstream with a valid/ready handshake.
- Supports redirect (flush and new PC) and halt (stop issuing, e.g. driven by the downstream except).

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
RESET_PC, 32'h00000000, PC value loaded on reset; must be word aligned

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mem_req  output  1  instruction memory request, registered
mem_addr  output  30  word address (PC[31:2]) of the outstanding request, registered
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  32  instruction word, valid when mem_ack=1
out_valid  output  1  FIFO head is valid
out_ready  input  1  downstream accepts the head this cycle
out_inst  output  32  instruction at FIFO head
out_pc  output  32  PC of the instruction at FIFO head
redirect  input  1  flush the queue and restart fetch at redirect_pc
redirect_pc  input  32  new PC; bits [1:0] ignored (treated as 0)
halt  input  1  when 1, no new requests are issued
count  output  log2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (reset=0, async):
  - PC=RESET_PC, FIFO empty, count=0, state=IDLE.
  - mem_req=0, mem_addr=RESET_PC[31:2], out_valid=0, out_inst=0, out_pc=0.
- At most one memory request is outstanding.
- Issue rule: a request may start only when halt=0 and count + outstanding < DEPTH. This guarantees every response has a free slot.
- State machine (IDLE, REQ, DROP):
  - IDLE: if the issue rule holds, set mem_req=1 and mem_addr=PC[31:2] next cycle, then go to REQ.
  - REQ: hold mem_req=1 with mem_addr stable until mem_ack=1. mem_ack may arrive in the first REQ cycle (zero wait).
    - On ack, push {PC, mem_rdata} and set PC=PC+4.
    - If the issue rule still holds (evaluated after this cycle's push and pop), stay in REQ with the new address. This gives back-to-back fetch at 1 instruction/cycle with a zero-wait memory.
    - Otherwise drop mem_req and go to IDLE.
  - DROP: the request in flight belongs to a flushed stream. Hold mem_req until mem_ack, discard mem_rdata (no push), then go to IDLE (or straight to REQ at the current PC if the issue rule holds).
- PC arithmetic: 32-bit modulo. 32'hFFFFFFFC + 4 = 32'h00000000; no flag is raised.
- Output and pop:
  - out_valid = (count != 0); out_inst and out_pc show the head entry combinationally from storage.
  - Pop occurs when out_valid & out_ready. A push and a pop in the same cycle leave count unchanged.
  - out_inst and out_pc are undefined when out_valid=0 except after reset (0).
- Redirect (highest priority):
  - FIFO is flushed (count=0 next cycle) and PC=redirect_pc & ~3.
  - A pop in the same cycle is ignored.
  - If in REQ with mem_ack=0: go to DROP (the request cannot be aborted).
  - If in REQ with mem_ack=1: the response is discarded, and REQ continues at the new PC next cycle if halt=0.
  - If in DROP: stay in DROP, update PC.
  - If in IDLE: normal issue at the new PC.
  - Redirect in back-to-back cycles: the last one wins.
- Halt:
  - Blocks only new issues. An outstanding request completes and is pushed (or dropped in DROP).
  - The FIFO keeps draining to downstream.
  - Deasserting halt resumes at the current PC.
- Full: count=DEPTH implies no request outstanding, so mem_req=0.
- Empty: out_valid=0, and out_ready is ignored.
- Mid-operation reset: returns immediately to reset values. An in-flight memory response after reset is ignored (mem_ack is ignored while in IDLE).
- mem_ack while mem_req=0 is ignored.
- Latency, zero-wait memory, from reset release:
  - cycle 1: mem_req=1
  - cycle 1: ack, push
  - cycle 2: out_valid=1 with out_pc=RESET_PC

Test Plan:
- Zero-wait memory returning inst=addr^32'hA5A5A5A5, out_ready=1 constantly -> out_pc sequence 0,4,8,... one per cycle with matching out_inst; count never exceeds 1.
- Memory ack delayed 3 cycles, out_ready=0 -> exactly DEPTH=4 entries (pc 0..12) fill; mem_req low with count=4. Then out_ready=1 -> pops in order and fetch resumes at pc 16.
- redirect with redirect_pc=32'h00000103 while a request for pc 8 waits (ack after 2 cycles) -> the pc-8 response is discarded, next pushed out_pc=32'h00000100, count=0 the cycle after redirect.
- redirect in the same cycle as mem_ack and an out_ready pop -> no push and no stale entry. The next out_valid shows the redirect target.
- RESET_PC=32'hFFFFFFF8, zero-wait memory -> out_pc sequence FFFFFFF8, FFFFFFFC, 00000000, 00000004.
- halt=1 asserted mid-stream -> the outstanding request completes and is pushed, no further mem_req, the FIFO drains. Also pulse reset low mid-request -> all outputs at reset values asynchronously, a later stray mem_ack is ignored.
